// File: rtl/carry_skip_pkg.sv
// rtl/carry_skip_pkg.sv - shared types and sizing helpers for the block-serial carry-skip adder
// Contents: FSM state enum, slice-count and skip-counter-width functions.
package carry_skip_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Number of BLOCK-bit slices, which is also the number of RUN cycles.
   function automatic int nb(input int width, input int block);
      return width / block;
   endfunction

   // Skip counter must hold 0..nb inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/carry_skip_seq_adder_if.sv
// rtl/carry_skip_seq_adder_if.sv - start/busy/done operand and result bundle
// master drives: start, A, B, Cin, sub
// slave drives : busy, done, S, Cout, V, skip_cnt
interface carry_skip_seq_adder_if
   import carry_skip_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int BLOCK = 4
);
   localparam int CW = cnt_w(nb(WIDTH, BLOCK));

   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             V;
   logic [CW-1:0]    skip_cnt;

   modport master (
      output start, A, B, Cin, sub,
      input  busy, done, S, Cout, V, skip_cnt
   );

   modport slave (
      input  start, A, B, Cin, sub,
      output busy, done, S, Cout, V, skip_cnt
   );

endinterface

// File: rtl/carry_skip_block.sv
// rtl/carry_skip_block.sv - one combinational BLOCK-bit carry-skip slice
// in : a, b (slice operands), cin (slice carry-in)
// out: s (slice sum), cout (skip-muxed carry-out), skip (all propagate bits set),
//      c_msb (carry into the slice's top bit)
module carry_skip_block #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] s,
   output logic             cout,
   output logic             skip,
   output logic             c_msb
);
   logic [BLOCK-1:0] p;
   logic [BLOCK-1:0] g;
   logic [BLOCK:0]   c;

   assign p = a ^ b;
   assign g = a & b;

   always_comb begin
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < BLOCK; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
   end

   assign s     = p ^ c[BLOCK-1:0];
   assign skip  = &p;
   assign c_msb = c[BLOCK-1];
   // When every bit propagates, the slice carry-out equals its carry-in, so the
   // ripple chain can be bypassed.
   assign cout  = skip ? cin : c[BLOCK];

endmodule

// File: rtl/carry_skip_seq_adder.sv
// rtl/carry_skip_seq_adder.sv - WIDTH-bit add/subtract, one carry-skip slice per clock
// clk, rst_n : clock and asynchronous active-low reset
// bus (slave): start/A/B/Cin/sub in; busy/done/S/Cout/V/skip_cnt out
module carry_skip_seq_adder
   import carry_skip_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int BLOCK = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   carry_skip_seq_adder_if.slave bus
);
   localparam int NB   = nb(WIDTH, BLOCK);
   localparam int CW   = cnt_w(NB);
   localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
   logic             carry_q, carry_d, cout_q, cout_d, v_q, v_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d, skip_q, skip_d;

   logic [BLOCK-1:0] sl_a, sl_b, sl_s;
   logic             sl_cout, sl_skip, sl_cmsb;
   logic [31:0]      base;
   logic [WIDTH-1:0] slice_mask;

   // Bit offset of the slice currently being processed.
   assign base       = 32'(idx_q) * BLOCK;
   assign slice_mask = WIDTH'({BLOCK{1'b1}}) << base;
   assign sl_a       = BLOCK'(a_q >> base);
   assign sl_b       = BLOCK'(b_q >> base);

   carry_skip_block #(.BLOCK(BLOCK)) u_block (
      .a     (sl_a),
      .b     (sl_b),
      .cin   (carry_q),
      .s     (sl_s),
      .cout  (sl_cout),
      .skip  (sl_skip),
      .c_msb (sl_cmsb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         v_q     <= 1'b0;
         skip_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         v_q     <= v_d;
         skip_q  <= skip_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      cout_d  = cout_q;
      v_d     = v_q;
      skip_d  = skip_q;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               // Subtract is A + ~B + 1, so B is inverted on capture and Cin is forced.
               a_d     = bus.A;
               b_d     = bus.B ^ {WIDTH{bus.sub}};
               carry_d = bus.sub ? 1'b1 : bus.Cin;
               sum_d   = '0;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sum_d   = (sum_q & ~slice_mask) | (WIDTH'(sl_s) << base);
            carry_d = sl_cout;
            cnt_d   = cnt_q + CW'(sl_skip);
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDXW'(NB - 1)) begin
               // Results publish on the RUN->DONE edge and hold until the next one.
               s_d     = sum_d;
               cout_d  = sl_cout;
               v_d     = sl_cmsb ^ sl_cout;
               skip_d  = cnt_d;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy     = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
   assign bus.S        = s_q;
   assign bus.Cout     = cout_q;
   assign bus.V        = v_q;
   assign bus.skip_cnt = skip_q;

endmodule

// File: doc/carry_skip_seq_adder.md
Name: carry_skip_seq_adder

Overview:
Parametrised, block-serial successor to the team's 4-bit carry-skip adder. It computes WIDTH-bit add or subtract one BLOCK-bit carry-skip slice per clock, under a start/busy/done handshake. It also reports carry-out, signed overflow, and the number of slices whose carry took the skip path. It sits in the ALU datapath as the arithmetic unit for widths where a full-width combinational chain is too slow.

Parameters:
WIDTH, 8, operand and result width in bits; must be a multiple of BLOCK and at least 2.
BLOCK, 4, bits processed per cycle, i.e. the carry-skip group size; must be at least 1.
(derived) NB = WIDTH/BLOCK, the number of slices and the number of RUN cycles.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE or DONE
A  in  WIDTH  operand A; captured when start is accepted
B  in  WIDTH  operand B; captured when start is accepted
Cin  in  1  carry-in for add; ignored when sub=1
sub  in  1  0 = A+B+Cin, 1 = A+~B+1 (A-B); captured when start is accepted
busy  out  1  high in RUN
done  out  1  one-cycle pulse when results become valid
S  out  WIDTH  result
Cout  out  1  carry out of the MSB slice
V  out  1  signed overflow: carry into MSB XOR carry out of MSB
skip_cnt  out  $clog2(NB+1)  number of slices where all propagate bits were 1

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset forces: state=IDLE, busy=0, done=0, S=0, Cout=0, V=0, skip_cnt=0. Internal operand, carry, slice-index and partial-sum registers are also cleared.
- FSM states are IDLE, RUN and DONE.
- IDLE: if start=1, capture A, B^{WIDTH{sub}}, and carry = sub ? 1 : Cin. Set idx=0 and clear the partial count, then go to RUN. Otherwise stay in IDLE.
- RUN: busy=1. Each cycle, process slice idx (bits idx*BLOCK+BLOCK-1 : idx*BLOCK):
  - P = a^b per bit.
  - The slice is ripple-summed with the carry register.
  - Slice carry-out = (&P) ? carry_in : ripple_carry_out.
  - If &P, the partial skip count increments.
  - The partial-sum slice is written, the carry register is updated, and idx increments.
  - For the MSB slice, the carry into bit WIDTH-1 is also recorded.
  - After slice NB-1 is processed, go to DONE. Total RUN cycles = NB.
- DONE: done=1 for exactly this one cycle.
  - S, Cout, V and skip_cnt are loaded from the internal registers on the RUN→DONE edge, so they are valid while done=1.
  - These outputs hold their values until the next accepted start completes.
  - In DONE, start=1 is accepted exactly as in IDLE (back-to-back operation) and the next state is RUN. Otherwise the next state is IDLE.
- Latency: start sampled at edge t; busy high for cycles t+1..t+NB; done high for cycle t+NB+1.
- start while busy is ignored: no capture, and the operation in flight is unaffected.
- A, B, Cin and sub may change freely after capture.
- Outputs S, Cout, V and skip_cnt do not change during RUN; they keep the previous result.
- Reset asserted mid-RUN aborts the operation immediately and all outputs return to reset values. No done pulse is produced.
- NB=1 (BLOCK=WIDTH) is legal: one RUN cycle, done on t+2.
- Arithmetic is modulo 2^WIDTH. Cout on subtract means "no borrow" (A ≥ B unsigned).

Decomposition:
- Package carry_skip_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - a function nb(WIDTH, BLOCK);
  - a function cnt_w(nb) = $clog2(nb+1).
- Sub-module carry_skip_block: purely combinational, parametrised by BLOCK.
  - Inputs: a, b, cin.
  - Outputs: s, cout (skip-muxed), skip (= &P), c_msb (carry into the slice's top bit).
- The top level instantiates carry_skip_block once and muxes the slice selected by idx.

Test Plan:
- WIDTH=8, BLOCK=4; A=0xF0, B=0x0F, Cin=1, sub=0, start pulse -> busy 2 cycles, done on cycle 3; S=0x00, Cout=1, V=0, skip_cnt=2.
- A=0x7F, B=0x01, Cin=0, sub=0 -> S=0x80, Cout=0, V=1, skip_cnt=0.
- A=0x05, B=0x07, sub=1 (Cin=1 driven, must be ignored) -> S=0xFE, Cout=0, V=0, skip_cnt=1. Then hold start=1 on the done cycle with A=0x07, B=0x05, sub=1 -> second done 3 cycles later, S=0x02, Cout=1.
- Pulse start during busy with different operands -> no effect; first result S=0x10 for A=0x0F, B=0x01, Cin=0; exactly one done pulse.
- Deassert rst_n on the 1st RUN cycle -> busy=0 and outputs 0 immediately; no done pulse; the next start completes normally.
- WIDTH=16, BLOCK=4; A=0xFFFF, B=0x0001, Cin=0 -> busy 4 cycles, S=0x0000, Cout=1, V=0, skip_cnt=3.
